// File: rtl/morra_fsmd_param.sv
// Morra Cinese (rock-paper-scissors) game FSMD, parametrised.
// Moves are scored round by round. The game ends early on a score margin once
// MIN_ROUNDS valid rounds have been played, or it ends when the configured
// round limit is reached. The winner of the previous valid round may not
// repeat the move that won it. All results are registered, with one cycle of
// latency from the inputs.
module morra_fsmd_param #(
  parameter int MIN_ROUNDS = 4,
  parameter int LEAD       = 2,
  parameter int CFG_OFFSET = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  input  logic             INIZIA,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] ROUND,
  output logic [CNT_W-1:0] SCORE1,
  output logic [CNT_W-1:0] SCORE2,
  output logic             BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_END} state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [CNT_W-1:0] MIN_R  = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0] CFG_W  = CNT_W'(CFG_OFFSET);
  localparam logic [CNT_W:0]   LEAD_W = (CNT_W+1)'(LEAD);

  state_t           state, state_d;
  logic [CNT_W-1:0] max_r, max_d;
  logic             lw_valid, lw_valid_d;   // a valid, non-draw round has a winner on record
  logic             lw_p2, lw_p2_d;         // that winner was player 2
  logic [1:0]       lw_move, lw_move_d;     // the move that won it
  logic [1:0]       manche_d, partita_d;
  logic [CNT_W-1:0] round_d, score1_d, score2_d;

  // Round evaluation signals
  logic             both_moved, repeat_move, round_valid;
  logic             is_draw, p1_win;
  logic [CNT_W-1:0] round_n, s1_n, s2_n;
  logic [CNT_W:0]   diff;
  logic             margin_end, limit_end, game_over;
  logic [1:0]       round_res, leader_res, final_res;

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Score the current moves and decide whether this round ends the game
  always_comb begin
    both_moved  = (PRIMO != 2'b00) && (SECONDO != 2'b00);
    repeat_move = lw_valid && (lw_p2 ? (SECONDO == lw_move) : (PRIMO == lw_move));
    round_valid = (state == S_PLAY) && both_moved && !repeat_move;

    is_draw = (PRIMO == SECONDO);
    // paper beats rock, scissors beats paper, rock beats scissors
    p1_win  = ((PRIMO == 2'b10) && (SECONDO == 2'b01)) ||
              ((PRIMO == 2'b11) && (SECONDO == 2'b10)) ||
              ((PRIMO == 2'b01) && (SECONDO == 2'b11));

    if (is_draw)     round_res = RES_DRAW;
    else if (p1_win) round_res = RES_P1;
    else             round_res = RES_P2;

    round_n = ROUND + 1'b1;
    s1_n    = SCORE1 + CNT_W'(round_res == RES_P1);
    s2_n    = SCORE2 + CNT_W'(round_res == RES_P2);

    // Magnitude is formed one bit wider than the scores
    if (s1_n >= s2_n) diff = {1'b0, s1_n} - {1'b0, s2_n};
    else              diff = {1'b0, s2_n} - {1'b0, s1_n};

    leader_res = (s1_n > s2_n) ? RES_P1 : RES_P2;
    if (s1_n > s2_n)      final_res = RES_P1;
    else if (s2_n > s1_n) final_res = RES_P2;
    else                  final_res = RES_DRAW;

    margin_end = (round_n >= MIN_R) && (diff >= LEAD_W);
    limit_end  = (round_n == max_r);
    game_over  = margin_end || limit_end;
  end

  // Next-state logic; INIZIA restarts the game from any state
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (INIZIA) state_d = S_PLAY;
      S_PLAY: begin
        if (INIZIA)                        state_d = S_PLAY;
        else if (round_valid && game_over) state_d = S_END;
      end
      S_END:  if (INIZIA) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath registers and registered outputs
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    max_d      = max_r;
    lw_valid_d = lw_valid;
    lw_p2_d    = lw_p2;
    lw_move_d  = lw_move;
    round_d    = ROUND;
    score1_d   = SCORE1;
    score2_d   = SCORE2;
    manche_d   = RES_NONE;
    partita_d  = PARTITA;

    if (INIZIA) begin
      max_d      = {{(CNT_W-4){1'b0}}, PRIMO, SECONDO} + CFG_W;
      lw_valid_d = 1'b0;
      lw_p2_d    = 1'b0;
      lw_move_d  = 2'b00;
      round_d    = '0;
      score1_d   = '0;
      score2_d   = '0;
      partita_d  = RES_NONE;
    end else if (round_valid) begin
      round_d    = round_n;
      score1_d   = s1_n;
      score2_d   = s2_n;
      manche_d   = round_res;
      lw_valid_d = !is_draw;
      lw_p2_d    = (round_res == RES_P2);
      lw_move_d  = (round_res == RES_P2) ? SECONDO : PRIMO;
      if (margin_end)     partita_d = leader_res;
      else if (limit_end) partita_d = final_res;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r    <= '0;
      lw_valid <= 1'b0;
      lw_p2    <= 1'b0;
      lw_move  <= 2'b00;
      ROUND    <= '0;
      SCORE1   <= '0;
      SCORE2   <= '0;
      MANCHE   <= RES_NONE;
      PARTITA  <= RES_NONE;
    end else begin
      max_r    <= max_d;
      lw_valid <= lw_valid_d;
      lw_p2    <= lw_p2_d;
      lw_move  <= lw_move_d;
      ROUND    <= round_d;
      SCORE1   <= score1_d;
      SCORE2   <= score2_d;
      MANCHE   <= manche_d;
      PARTITA  <= partita_d;
    end
  end

  assign BUSY = (state == S_PLAY);

endmodule

// File: tb/tb_morra_fsmd_param.sv
// Directed testbench for morra_fsmd_param with hand-computed expectations.
module tb_morra_fsmd_param;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       PRIMO, SECONDO;
  logic             INIZIA;
  logic [1:0]       MANCHE, PARTITA;
  logic [CNT_W-1:0] ROUND, SCORE1, SCORE2;
  logic             BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  morra_fsmd_param #(
    .MIN_ROUNDS(4), .LEAD(2), .CFG_OFFSET(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .PRIMO(PRIMO), .SECONDO(SECONDO), .INIZIA(INIZIA),
    .MANCHE(MANCHE), .PARTITA(PARTITA), .ROUND(ROUND),
    .SCORE1(SCORE1), .SCORE2(SCORE2), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, clock once, sample 1 ns after the edge
  task automatic step(input logic [1:0] p1, input logic [1:0] p2, input logic ini);
    PRIMO = p1; SECONDO = p2; INIZIA = ini;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int m, input int p, input int r,
                            input int s1, input int s2, input int b);
    check({tag, ".manche"},  int'(MANCHE),  m);
    check({tag, ".partita"}, int'(PARTITA), p);
    check({tag, ".round"},   int'(ROUND),   r);
    check({tag, ".score1"},  int'(SCORE1),  s1);
    check({tag, ".score2"},  int'(SCORE2),  s2);
    check({tag, ".busy"},    int'(BUSY),    b);
  endtask

  initial begin
    rst = 1'b1; PRIMO = 2'b00; SECONDO = 2'b00; INIZIA = 1'b0;
    #1;
    expect_all("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // IDLE ignores moves
    step(2'b01, 2'b11, 1'b0);
    expect_all("idle", 0, 0, 0, 0, 0, 0);

    // Margin win: MAX=4, P1 wins four rounds
    step(2'b00, 2'b00, 1'b1);
    expect_all("m.start", 0, 0, 0, 0, 0, 1);
    step(2'b01, 2'b11, 1'b0); expect_all("m.r1", 1, 0, 1, 1, 0, 1);
    step(2'b10, 2'b01, 1'b0); expect_all("m.r2", 1, 0, 2, 2, 0, 1);
    step(2'b11, 2'b10, 1'b0); expect_all("m.r3", 1, 0, 3, 3, 0, 1);
    step(2'b01, 2'b11, 1'b0); expect_all("m.r4", 1, 1, 4, 4, 0, 0);
    step(2'b10, 2'b01, 1'b0); expect_all("m.end", 0, 1, 4, 4, 0, 0);

    // Invalid rounds: missing move, winner repeating its winning move
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b11, 1'b0); expect_all("inv.r1", 1, 0, 1, 1, 0, 1);
    step(2'b00, 2'b10, 1'b0); expect_all("inv.nomove", 0, 0, 1, 1, 0, 1);
    step(2'b01, 2'b10, 1'b0); expect_all("inv.repeat", 0, 0, 1, 1, 0, 1);
    // Two-point lead at round 2 is below MIN_ROUNDS: game continues
    step(2'b10, 2'b01, 1'b0); expect_all("inv.r2", 1, 0, 2, 2, 0, 1);

    // Async reset mid-game, between clock edges
    #2 rst = 1'b1;
    #1 expect_all("arst.now", 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(2'b01, 2'b11, 1'b0); expect_all("arst.ignore", 0, 0, 0, 0, 0, 0);

    // Round limit reached with equal scores: MAX=4
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b11, 1'b0); expect_all("d.r1", 1, 0, 1, 1, 0, 1);
    step(2'b10, 2'b11, 1'b0); expect_all("d.r2", 2, 0, 2, 1, 1, 1);
    step(2'b01, 2'b01, 1'b0); expect_all("d.r3", 3, 0, 3, 1, 1, 1);
    step(2'b10, 2'b10, 1'b0); expect_all("d.r4", 3, 3, 4, 1, 1, 0);

    // Long game: MAX=19 via config 11/11, all draws
    step(2'b11, 2'b11, 1'b1);
    for (int i = 1; i <= 19; i++) begin
      step(2'b01, 2'b01, 1'b0);
      check($sformatf("long.r%0d.round", i), int'(ROUND), i);
      check($sformatf("long.r%0d.partita", i), int'(PARTITA), (i == 19) ? 3 : 0);
    end
    check("long.busy", int'(BUSY), 0);
    step(2'b01, 2'b01, 1'b0);
    expect_all("long.after", 0, 3, 19, 0, 0, 0);

    // Restart during PLAY at round 3, config 01/10 -> MAX=10
    step(2'b00, 2'b00, 1'b1);
    repeat (3) step(2'b01, 2'b01, 1'b0);
    check("rs.pre.round", int'(ROUND), 3);
    step(2'b01, 2'b10, 1'b1);
    expect_all("rs.play", 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      step(2'b10, 2'b10, 1'b0);
      check($sformatf("rs.r%0d.partita", i), int'(PARTITA), (i == 10) ? 3 : 0);
    end
    check("rs.max.round", int'(ROUND), 10);

    // Restart from END
    step(2'b01, 2'b10, 1'b1);
    expect_all("rs.end", 0, 0, 0, 0, 0, 1);
    step(2'b11, 2'b10, 1'b0);
    expect_all("rs.end.r1", 1, 0, 1, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
